// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Latency: n/a (types only).
// Backpressure: n/a. Divider datapath is enabled by defining MULDIV_DIV_EN.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = $clog2(ITERS);

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // True for the two ops that need the divider datapath
  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIVU) || (o == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring trial subtract for divide.
// Latency: 0 cycles (pure combinational).
// Backpressure: none. The mode input and divide path exist only with MULDIV_DIV_EN.
module muldiv_step
  import muldiv_pkg::*;
(
`ifdef MULDIV_DIV_EN
  input  logic            mode,
`endif
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0]   sum;
  logic [XLEN-1:0] mul_hi;
  logic [XLEN-1:0] mul_lo;
`ifdef MULDIV_DIV_EN
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] diff;
  logic            ge;
  logic [XLEN-1:0] div_hi;
  logic [XLEN-1:0] div_lo;
`endif

  // Multiply: add b when the multiplier LSB is set, then shift {carry,hi,lo} right by one
  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    mul_hi = sum[XLEN:1];
    mul_lo = {sum[0], lo[XLEN-1:1]};
  end

`ifdef MULDIV_DIV_EN
  // Divide: shift dividend MSB into the 33-bit partial remainder, subtract b if it fits.
  // When it fits the true difference is below b, so a 32-bit subtract is exact.
  always_comb begin
    trial  = {hi, lo[XLEN-1]};
    ge     = (trial >= {1'b0, b});
    diff   = trial[XLEN-1:0] - b;
    div_hi = ge ? diff : trial[XLEN-1:0];
    div_lo = {lo[XLEN-2:0], ge};
  end

  // Pick the result of the active operation
  always_comb begin
    hi_nxt = mode ? div_hi : mul_hi;
    lo_nxt = mode ? div_lo : mul_lo;
  end
`else
  // Multiply is the only iterated operation in this build
  always_comb begin
    hi_nxt = mul_hi;
    lo_nxt = mul_lo;
  end
`endif

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative 32-bit unsigned MUL/MULHU/DIVU/REMU, one iteration per clock.
// Latency: done 32 edges after the start edge (start-edge itself for unsupported div ops).
// Backpressure: start only accepted in IDLE, never queued; define MULDIV_DIV_EN for the divider.
module muldiv_iter_unit #(
  parameter int XLEN  = muldiv_pkg::XLEN,
  parameter int ITERS = muldiv_pkg::ITERS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] result
);

  import muldiv_pkg::*;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            err_q, err_d;
  logic            hi_sel_q, hi_sel_d;   // result comes from hi (MULHU/REMU)
`ifdef MULDIV_DIV_EN
  logic            div_q, div_d;
`endif

  op_e             op_in;
  logic            last_iter;
  logic            short_path;
  logic [XLEN-1:0] step_hi;
  logic [XLEN-1:0] step_lo;

  assign op_in     = op_e'(op);
  assign last_iter = (cnt_q == CNT_W'(ITERS - 1));
`ifdef MULDIV_DIV_EN
  assign short_path = 1'b0;
`else
  assign short_path = op_is_div(op_in);
`endif

  muldiv_step u_step (
`ifdef MULDIV_DIV_EN
    .mode   (div_q),
`endif
    .hi     (hi_q),
    .lo     (lo_q),
    .b      (b_q),
    .hi_nxt (step_hi),
    .lo_nxt (step_lo)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: kill only matters in RUN, start only in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = short_path ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (kill)           state_d = ST_IDLE;
        else if (last_iter) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: busy and done are decoded directly from state so they can never overlap
  always_comb begin
    busy   = (state_q == ST_RUN);
    done   = (state_q == ST_DONE);
    err    = err_q;
    result = result_q;
  end

  // Datapath next values: latch operands on start, iterate in RUN, capture result on last step
  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;
    hi_sel_d = hi_sel_q;
`ifdef MULDIV_DIV_EN
    div_d    = div_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d    = '0;
          hi_d     = '0;
          lo_d     = a;
          b_d      = b;
          hi_sel_d = op_in[0];
`ifdef MULDIV_DIV_EN
          div_d    = op_is_div(op_in);
`endif
          if (short_path) begin
            result_d = '0;
            err_d    = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!kill) begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + 1'b1;
          if (last_iter) begin
            result_d = hi_sel_q ? step_hi : step_lo;
            err_d    = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      hi_sel_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q    <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
      hi_sel_q <= hi_sel_d;
`ifdef MULDIV_DIV_EN
      div_q    <= div_d;
`endif
    end
  end

endmodule
